// File: rtl/dac_sample_buffer_pkg.sv
// Shared types and helpers for the dac sample buffer: per-cycle event bundle
// and the code clamp applied when a sample is handed to the dac.
package dac_sample_buffer_pkg;

  // One-cycle events derived from the handshake and the dac strobe.
  typedef struct packed {
    logic push;
    logic pop;
    logic underflow;
  } buf_events_t;

  // Clamp a stored sample to the largest duty code the dac window can express.
  function automatic int unsigned clamp_code(int unsigned value, int unsigned max_code);
    return (value > max_code) ? max_code : value;
  endfunction

endpackage

// File: rtl/dac_sample_buffer_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty/count derive only from
// the registered pointers so no input reaches them combinationally.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dac_sample_buffer.sv
// Elastic sample source feeding the PWM dac: buffers producer samples and
// presents one clamped code per dac window, counting strobes that find it empty.
module dac_sample_buffer
  import dac_sample_buffer_pkg::*;
#(
  parameter int CODE_WIDTH        = 10,
  parameter int DEPTH             = 8,
  parameter int CYCLES_PER_WINDOW = 1024,
  parameter int UNDERFLOW_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CODE_WIDTH-1:0]       in_sample,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        next_sample,
  output logic [CODE_WIDTH-1:0]       code,
  output logic [$clog2(DEPTH):0]      fill_level,
  output logic [UNDERFLOW_WIDTH-1:0]  underflow_count
);

  localparam int unsigned MAX_CODE = unsigned'(CYCLES_PER_WINDOW - 1);
  localparam logic [UNDERFLOW_WIDTH-1:0] UF_ONE = {{(UNDERFLOW_WIDTH-1){1'b0}}, 1'b1};

  logic                  full;
  logic                  empty;
  logic [CODE_WIDTH-1:0] head;
  buf_events_t           ev;

  // Handshake: a sample transfers on any posedge where in_valid && in_ready;
  // in_ready is !full from registered pointers, so a same-cycle pop never
  // reopens it and in_valid may be held without the sample being duplicated.
  assign in_ready = !full;

  // An empty FIFO never bypasses a same-cycle push: that strobe is an underflow.
  always_comb begin
    ev           = '0;
    ev.push      = in_valid && !full;
    ev.pop       = next_sample && !empty;
    ev.underflow = next_sample && empty;
  end

  sync_fifo #(
    .WIDTH (CODE_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ev.push),
    .push_data (in_sample),
    .pop       (ev.pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fill_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code <= '0;
    end else if (ev.pop) begin
      code <= CODE_WIDTH'(clamp_code(32'(head), MAX_CODE));
    end
  end

  // Saturates at all-ones so a long starvation never reads as a small count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_count <= '0;
    end else if (ev.underflow && (underflow_count != '1)) begin
      underflow_count <= underflow_count + UF_ONE;
    end
  end

endmodule

// File: tb/tb_dac_sample_buffer.sv
// Self-checking bench for dac_sample_buffer: directed windows plus randomized
// traffic compared every cycle against a queue-based model of the buffer.
module tb_dac_sample_buffer;

  localparam int CW    = 10;
  localparam int DEPTH = 8;
  localparam int CPW   = 8;
  localparam int UW    = 4;
  localparam int FW    = $clog2(DEPTH) + 1;
  localparam int UF_MAX = (1 << UW) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  logic [CW-1:0] in_sample = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          next_sample = 1'b0;
  logic [CW-1:0] code;
  logic [FW-1:0] fill_level;
  logic [UW-1:0] underflow_count;

  dac_sample_buffer #(
    .CODE_WIDTH        (CW),
    .DEPTH             (DEPTH),
    .CYCLES_PER_WINDOW (CPW),
    .UNDERFLOW_WIDTH   (UW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_sample       (in_sample),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .next_sample     (next_sample),
    .code            (code),
    .fill_level      (fill_level),
    .underflow_count (underflow_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // behavioural model: a queue of stored samples, the last handed-out code,
  // and a saturating strobe-while-empty count
  logic [CW-1:0] exp_q[$];
  int  m_code = 0;
  int  m_uf   = 0;
  int  m_pop_v;
  bit  m_room;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_code = 0;
      m_uf   = 0;
    end else begin
      m_room = (exp_q.size() < DEPTH);
      if (next_sample) begin
        if (exp_q.size() > 0) begin
          m_pop_v = int'(exp_q.pop_front());
          m_code  = (m_pop_v > CPW - 1) ? CPW - 1 : m_pop_v;
        end else if (m_uf < UF_MAX) begin
          m_uf = m_uf + 1;
        end
      end
      if (in_valid && m_room) exp_q.push_back(in_sample);
    end
  end

  // scoreboard compare on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst_n && check_en) begin
      check("code", int'(code), m_code);
      check("fill_level", int'(fill_level), exp_q.size());
      check("in_ready", int'(in_ready), (exp_q.size() < DEPTH) ? 1 : 0);
      check("underflow_count", int'(underflow_count), m_uf);
    end
  end

  // driver tasks
  task automatic cycle(bit v, int d, bit ns);
    in_valid    = v;
    in_sample   = CW'(d);
    next_sample = ns;
    @(posedge clk);
    #1;
  endtask

  task automatic window();
    repeat (CPW - 1) cycle(1'b0, 0, 1'b0);
    cycle(1'b0, 0, 1'b1);
  endtask

  int ph;
  bit r_ns;
  bit r_v;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_code", int'(code), 0);
    check("reset_fill", int'(fill_level), 0);
    check("reset_uf", int'(underflow_count), 0);
    check("reset_in_ready", int'(in_ready), 1);
    check_en = 1'b1;

    // three samples out in order over three windows
    cycle(1'b1, 3, 1'b0);
    cycle(1'b1, 5, 1'b0);
    cycle(1'b1, 1, 1'b0);
    check("t2_fill3", int'(fill_level), 3);
    window(); check("t2_code3", int'(code), 3); check("t2_fill2", int'(fill_level), 2);
    window(); check("t2_code5", int'(code), 5);
    window(); check("t2_code1", int'(code), 1); check("t2_fill0", int'(fill_level), 0);

    // starvation holds the code and saturates the counter
    window(); window();
    check("t3_code_hold", int'(code), 1);
    check("t3_uf2", int'(underflow_count), 2);
    repeat (UF_MAX - 2) cycle(1'b0, 0, 1'b1);
    check("t3_uf_max", int'(underflow_count), UF_MAX);
    repeat (3) cycle(1'b0, 0, 1'b1);
    check("t3_uf_sat", int'(underflow_count), UF_MAX);

    // asynchronous reset in the middle of traffic
    cycle(1'b1, 6, 1'b0);
    cycle(1'b1, 2, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t1_code", int'(code), 0);
    check("t1_fill", int'(fill_level), 0);
    check("t1_uf", int'(underflow_count), 0);
    check("t1_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // fill to the brim with in_valid held
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, i + 1, 1'b0);
    check("t4_fill8", int'(fill_level), 8);
    check("t4_not_ready", int'(in_ready), 0);
    cycle(1'b1, 9, 1'b0);
    check("t4_fill8_hold", int'(fill_level), 8);
    cycle(1'b1, 9, 1'b1);
    check("t4_fill7", int'(fill_level), 7);
    check("t4_ready_again", int'(in_ready), 1);
    check("t4_code1", int'(code), 1);
    for (int k = 2; k <= DEPTH; k++) begin
      window();
      check("t4_drain_code", int'(code), (k > CPW - 1) ? CPW - 1 : k);
    end
    check("t4_drained", int'(fill_level), 0);

    // clamp at the window edge
    cycle(1'b1, 12, 1'b0); window(); check("t5_clamp12", int'(code), 7);
    cycle(1'b1, 7, 1'b0);  window(); check("t5_code7", int'(code), 7);
    cycle(1'b1, 0, 1'b0);  window(); check("t5_code0", int'(code), 0);

    // push coincident with a strobe on an empty buffer
    check("t6_uf0", int'(underflow_count), 0);
    cycle(1'b1, 4, 1'b1);
    check("t6_uf1", int'(underflow_count), 1);
    check("t6_fill1", int'(fill_level), 1);
    check("t6_code_hold", int'(code), 0);
    window();
    check("t6_code4", int'(code), 4);
    check("t6_fill0", int'(fill_level), 0);

    // randomized traffic: alternating heavy and sparse producer phases
    for (int n = 0; n < 4000; n++) begin
      ph   = (n / 500) % 2;
      r_ns = ((n % CPW) == CPW - 1) || ($urandom_range(0, 15) == 0);
      r_v  = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      cycle(r_v, int'($urandom_range(0, 15)), r_ns);
    end
    cycle(1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
